// File: rtl/rmi_pkg.sv
// ---------------------------------------------------------------------------
// rmi_pkg
// Shared definitions for the RMI schedule-loading blocks:
//   - RMI_DATA_W / RMI_ADDR_W : default word and BRAM address widths
//   - rmi_state_e             : bank writer controller states
//   - rmi_clog2               : width of a bank index (never less than 1 bit)
// No ports (package).
// ---------------------------------------------------------------------------
package rmi_pkg;

    localparam int RMI_DATA_W = 32;
    localparam int RMI_ADDR_W = 8;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOAD,
        ST_COMMIT,
        ST_WAIT_SYNC
    } rmi_state_e;

    // Bits needed to index 'value' items; a lone bank still gets one bit so
    // that select buses never collapse to zero width.
    function automatic int rmi_clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/rmi_bank_decode.sv
// ---------------------------------------------------------------------------
// rmi_bank_decode
// Turns a target bank index plus a write strobe into a registered one-hot
// write-enable vector, one bit per bank BRAM port.
// Ports:
//   clk      in   1            posedge clock
//   rst_n    in   1            asynchronous active-low reset
//   i_en     in   1            a write happens this cycle
//   i_bank   in   SEL_W        bank that receives the write
//   o_wr_en  out  NUM_BANKS    one-hot enable, valid the cycle after i_en
// ---------------------------------------------------------------------------
module rmi_bank_decode
    import rmi_pkg::*;
#(
    parameter int NUM_BANKS = 2,
    parameter int SEL_W     = rmi_clog2(NUM_BANKS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_en,
    input  logic [SEL_W-1:0]     i_bank,
    output logic [NUM_BANKS-1:0] o_wr_en
);

    logic [NUM_BANKS-1:0] w_oneHot;
    logic [NUM_BANKS-1:0] r_wrEn;

    // Compare against every bank number instead of shifting, so bank indices
    // that do not exist (non power-of-two bank counts) can never light a bit.
    always_comb begin
        w_oneHot = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_oneHot[b] = i_en && (i_bank == SEL_W'(b));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrEn <= '0;
        end else begin
            r_wrEn <= w_oneHot;
        end
    end

    assign o_wr_en = r_wrEn;

endmodule

// File: rtl/rmi_bank_writer.sv
// ---------------------------------------------------------------------------
// rmi_bank_writer
// Multi-bank schedule loader. Streams DEPTH schedule words into one of
// NUM_BANKS write-only BRAM ports, then commits that bank as the active read
// bank. Loads always target the bank after the one being read (round robin),
// so the bank in use by the reader is never overwritten. After reset the
// controller fills bank 0 on its own, without a tx request.
//
// Optional feature macro: RMI_SWAP_SYNC_EN
//   defined   : adds input frame_sync; a requested load's commit is held in
//               WAIT_SYNC until frame_sync is high (the power-up load does not
//               wait).
//   undefined : no frame_sync port; commit takes exactly one cycle.
//
// Ports:
//   clk          in   1            posedge clock
//   rst_n        in   1            asynchronous active-low reset
//   tx           in   1            load request, sampled every cycle
//   sched_valid  in   1            schedule word valid
//   sched_data   in   DATA_W       schedule word
//   frame_sync   in   1            swap permission (RMI_SWAP_SYNC_EN only)
//   sched_ready  out  1            sched_data accepted this cycle if valid
//   wr_en        out  NUM_BANKS    one-hot bank write enable
//   wr_addr      out  ADDR_W       write address (0 when no write)
//   wr_data      out  DATA_W       write data (0 when no write)
//   sel_bank     out  SEL_W        active read bank
//   sched_ok     out  1            sel_bank holds a complete schedule
//   busy         out  1            load or commit in progress
//   done         out  1            pulse, cycle after sel_bank is updated
//   tx_dropped   out  1            pulse, tx arrived while not idle
// ---------------------------------------------------------------------------
module rmi_bank_writer
    import rmi_pkg::*;
#(
    parameter int DATA_W    = RMI_DATA_W,
    parameter int ADDR_W    = RMI_ADDR_W,
    parameter int DEPTH     = 6,
    parameter int NUM_BANKS = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tx,
    input  logic                          sched_valid,
    input  logic [DATA_W-1:0]             sched_data,
`ifdef RMI_SWAP_SYNC_EN
    input  logic                          frame_sync,
`endif
    output logic                          sched_ready,
    output logic [NUM_BANKS-1:0]          wr_en,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [DATA_W-1:0]             wr_data,
    output logic [rmi_clog2(NUM_BANKS)-1:0] sel_bank,
    output logic                          sched_ok,
    output logic                          busy,
    output logic                          done,
    output logic                          tx_dropped
);

    localparam int SEL_W = rmi_clog2(NUM_BANKS);
    // One extra bit so the count can sit at DEPTH even when DEPTH == 2**ADDR_W.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DEPTH - 1);
    localparam logic [SEL_W-1:0] LAST_BANK = SEL_W'(NUM_BANKS - 1);

    rmi_state_e        r_state;
    logic [SEL_W-1:0]  r_tgtBank;
    logic [SEL_W-1:0]  r_selBank;
    logic [CNT_W-1:0]  r_count;
    logic              r_ready;
    logic              r_schedOk;
    logic              r_busy;
    logic              r_doneArm;
    logic              r_done;
    logic              r_txDropped;
    logic [ADDR_W-1:0] r_wrAddr;
    logic [DATA_W-1:0] r_wrData;

    logic              w_beat;
    logic              w_commitNow;
    logic [SEL_W-1:0]  w_nextBank;

    // Ready is only ever high in LOAD, so a beat needs no state qualifier.
    assign w_beat = sched_valid && r_ready;

    // Explicit wrap instead of '%' so non power-of-two bank counts go
    // NUM_BANKS-1 -> 0 without relying on the select width.
    assign w_nextBank = (r_selBank == LAST_BANK) ? '0 : r_selBank + 1'b1;

`ifdef RMI_SWAP_SYNC_EN
    // Marks the power-up fill, which is allowed to commit without frame_sync.
    logic r_initLoad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_initLoad <= 1'b0;
        end else if (r_state == ST_INIT) begin
            r_initLoad <= 1'b1;
        end else if ((r_state == ST_IDLE) && tx) begin
            r_initLoad <= 1'b0;
        end
    end

    assign w_commitNow = ((r_state == ST_COMMIT) && (r_initLoad || frame_sync)) ||
                         ((r_state == ST_WAIT_SYNC) && frame_sync);
`else
    assign w_commitNow = (r_state == ST_COMMIT);
`endif

    // Controller. The commit action sits after the case statement so both
    // COMMIT and WAIT_SYNC share it; its state assignment takes precedence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_INIT;
            r_tgtBank   <= '0;
            r_selBank   <= '0;
            r_count     <= '0;
            r_ready     <= 1'b0;
            r_schedOk   <= 1'b0;
            r_busy      <= 1'b0;
            r_doneArm   <= 1'b0;
            r_done      <= 1'b0;
            r_txDropped <= 1'b0;
            r_wrAddr    <= '0;
            r_wrData    <= '0;
        end else begin
            r_doneArm   <= 1'b0;
            r_done      <= r_doneArm;
            r_txDropped <= tx && (r_state != ST_IDLE);
            r_wrAddr    <= '0;
            r_wrData    <= '0;

            case (r_state)
                ST_INIT: begin
                    r_tgtBank <= '0;
                    r_count   <= '0;
                    r_ready   <= 1'b1;
                    r_busy    <= 1'b1;
                    r_state   <= ST_LOAD;
                end

                ST_IDLE: begin
                    if (tx) begin
                        r_tgtBank <= w_nextBank;
                        r_count   <= '0;
                        r_ready   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (w_beat) begin
                        r_wrAddr <= r_count[ADDR_W-1:0];
                        r_wrData <= sched_data;
                        r_count  <= r_count + 1'b1;
                        if (r_count == LAST_BEAT) begin
                            r_ready <= 1'b0;
                            r_state <= ST_COMMIT;
                        end
                    end
                end

                ST_COMMIT: begin
`ifdef RMI_SWAP_SYNC_EN
                    if (!w_commitNow) begin
                        r_state <= ST_WAIT_SYNC;
                    end
`endif
                end

                ST_WAIT_SYNC: begin
`ifndef RMI_SWAP_SYNC_EN
                    // Unreachable without swap sync; recover to idle anyway.
                    r_state <= ST_IDLE;
`endif
                end

                default: begin
                    r_state <= ST_INIT;
                end
            endcase

            if (w_commitNow) begin
                r_selBank <= r_tgtBank;
                r_schedOk <= 1'b1;
                r_doneArm <= 1'b1;
                r_busy    <= 1'b0;
                r_state   <= ST_IDLE;
            end
        end
    end

    rmi_bank_decode #(
        .NUM_BANKS (NUM_BANKS),
        .SEL_W     (SEL_W)
    ) u_decode (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_beat),
        .i_bank  (r_tgtBank),
        .o_wr_en (wr_en)
    );

    assign sched_ready = r_ready;
    assign wr_addr     = r_wrAddr;
    assign wr_data     = r_wrData;
    assign sel_bank    = r_selBank;
    assign sched_ok    = r_schedOk;
    assign busy        = r_busy;
    assign done        = r_done;
    assign tx_dropped  = r_txDropped;

endmodule

// File: tb/tb_rmi_bank_writer.sv
// ---------------------------------------------------------------------------
// tb_rmi_bank_writer
// Randomised scoreboard bench for rmi_bank_writer with three banks so the
// non power-of-two wrap is exercised. Drivers push expected writes/commits as
// they issue stimulus; a monitor pops and compares whenever the DUT writes or
// pulses done.
// ---------------------------------------------------------------------------
module tb_rmi_bank_writer;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 6;
   localparam int NB     = 3;
   localparam int SEL_W  = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              tx = 1'b0;
   logic              sched_valid = 1'b0;
   logic [DATA_W-1:0] sched_data = '0;
   logic              sched_ready;
   logic [NB-1:0]     wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [SEL_W-1:0]  sel_bank;
   logic              sched_ok;
   logic              busy;
   logic              done;
   logic              tx_dropped;

   typedef struct {
      int          bank;
      int          addr;
      logic [31:0] data;
   } wr_t;

   wr_t wrQ[$];
   int  selQ[$];

   int vectors = 0;
   int miscompares = 0;
   int expSel = 0;
   int expDrops = 0;
   int obsDrops = 0;

   // Free-running clock
   always #5 clk = ~clk;

   rmi_bank_writer #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .DEPTH     (DEPTH),
      .NUM_BANKS (NB)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .tx          (tx),
      .sched_valid (sched_valid),
      .sched_data  (sched_data),
`ifdef RMI_SWAP_SYNC_EN
      .frame_sync  (1'b1),
`endif
      .sched_ready (sched_ready),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .sel_bank    (sel_bank),
      .sched_ok    (sched_ok),
      .busy        (busy),
      .done        (done),
      .tx_dropped  (tx_dropped)
   );

   // Single comparison point shared by the monitor and the drivers
   task automatic checkOutput(input string name, input longint actual, input longint expected);
      vectors++;
      if (actual != expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT writes a bank or commits
   initial begin
      wr_t e;
      int  s;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (wr_en != '0) begin
               if (wrQ.size() == 0) begin
                  checkOutput("unexpected_write", longint'(wr_en), 0);
               end else begin
                  e = wrQ.pop_front();
                  checkOutput("wr_en", longint'(wr_en), longint'(1 << e.bank));
                  checkOutput("wr_addr", longint'(wr_addr), longint'(e.addr));
                  checkOutput("wr_data", longint'(wr_data), longint'(e.data));
               end
            end else begin
               checkOutput("idle_addr_data", longint'({wr_addr, wr_data}), 0);
            end
            if (done) begin
               if (selQ.size() == 0) begin
                  checkOutput("unexpected_done", longint'(done), 0);
               end else begin
                  s = selQ.pop_front();
                  checkOutput("sel_bank", longint'(sel_bank), longint'(s));
                  checkOutput("sched_ok", longint'(sched_ok), 1);
               end
            end
            if (tx_dropped) obsDrops++;
         end
      end
   end

   // Streams one schedule into bank tgt with random valid gaps; optionally
   // pulses tx once mid-load, which must be dropped.
   task automatic applyStimulus(input int tgt, input int gapPct, input bit midTx);
      int k;
      int cycles;
      bit txSent;
      k = 0;
      cycles = 0;
      txSent = 1'b0;
      selQ.push_back(tgt);
      while (k < DEPTH && cycles < 200) begin
         @(posedge clk); #1;
         tx = 1'b0;
         sched_valid = ($urandom_range(99) >= gapPct);
         sched_data = $urandom;
         if (midTx && !txSent && k >= 2) begin
            tx = 1'b1;
            txSent = 1'b1;
            expDrops++;
         end
         @(negedge clk);
         if (sched_valid && sched_ready) begin
            wrQ.push_back('{tgt, k, sched_data});
            k++;
         end
         cycles++;
      end
      @(posedge clk); #1;
      sched_valid = 1'b0;
      tx = 1'b0;
      if (k < DEPTH) checkOutput("load_timeout_beats", k, DEPTH);
      expSel = tgt;
   endtask

   // Waits for the monitor to see the commit, then checks the idle outputs
   task automatic waitDone();
      int c;
      c = 0;
      while (selQ.size() != 0 && c < 100) begin
         @(negedge clk); #1;
         c++;
      end
      if (selQ.size() != 0) begin
         checkOutput("done_timeout", selQ.size(), 0);
         selQ.delete();
      end
      checkOutput("pending_writes", wrQ.size(), 0);
      wrQ.delete();
      @(negedge clk); #1;
      checkOutput("idle_busy_ready", longint'({busy, sched_ready}), 0);
      checkOutput("idle_sel_bank", longint'(sel_bank), longint'(expSel));
   endtask

   // Request a load from IDLE towards the next bank in round-robin order
   task automatic requestLoad(input int gapPct, input bit midTx);
      repeat ($urandom_range(3)) @(posedge clk);
      @(posedge clk); #1;
      tx = 1'b1;
      applyStimulus((expSel + 1) % NB, gapPct, midTx);
      waitDone();
   endtask

   function automatic longint allOutputs();
      return longint'({sched_ready, wr_en, wr_addr, wr_data, sel_bank,
                       sched_ok, busy, done, tx_dropped});
   endfunction

   initial begin
      // Power-up reset
      repeat (3) @(negedge clk);
      checkOutput("reset_outputs", allOutputs(), 0);
      rst_n = 1'b1;

      // Power-up fill of bank 0 with a continuous stream
      applyStimulus(0, 0, 1'b0);
      waitDone();

      // Round-robin loads with random gaps and dropped mid-load requests
      for (int i = 0; i < 7; i++) begin
         requestLoad((i % 3) * 30, i[0]);
      end

      // Reset in the middle of a load: partial bank is abandoned
      begin
         int k;
         int cycles;
         k = 0;
         cycles = 0;
         @(posedge clk); #1;
         tx = 1'b1;
         while (k < 3 && cycles < 50) begin
            @(posedge clk); #1;
            tx = 1'b0;
            sched_valid = 1'b1;
            sched_data = $urandom;
            @(negedge clk);
            if (sched_ready) begin
               wrQ.push_back('{(expSel + 1) % NB, k, sched_data});
               k++;
            end
            cycles++;
         end
         checkOutput("pre_reset_beats", k, 3);
         @(posedge clk); #2;
         rst_n = 1'b0;
         #1;
         checkOutput("async_reset_outputs", allOutputs(), 0);
         sched_valid = 1'b0;
         wrQ.delete();
         selQ.delete();
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         expSel = 0;
      end

      // Refill after reset goes back to bank 0, then continue round robin
      applyStimulus(0, 40, 1'b0);
      waitDone();
      for (int i = 0; i < 3; i++) begin
         requestLoad(20, 1'b1);
      end

      repeat (5) @(negedge clk);
      checkOutput("tx_dropped_count", obsDrops, expDrops);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
